// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and a
// width helper so one-bit-minimum counters never collapse to zero width.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts while enabled, wraps at CLKS-1 and flags the
// last cycle of each period. Shared between the UART TX and RX paths.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = clog2_min1(CLKS);
  localparam logic [W-1:0] LAST = W'(CLKS - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Elaboration-configurable UART transmitter with a one-entry holding
// register so a producer can queue the next byte while a frame is on the line.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_par
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int IW = clog2_min1(DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic ODD = (PARITY == PAR_ODD);

  state_t               state, state_d;
  logic [DATA_BITS-1:0] hold, shift, shift_d;
  logic                 hold_full, par, serial, done;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 tick, load, frame_end, serial_d;

  uart_baud_tick #(.CLKS(CLKS_PER_BIT)) u_baud (
    .clk  (i_Clock),
    .rst  (i_Reset),
    .en   (state != S_IDLE),
    .clr  (state == S_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d   = state;
    shift_d   = shift;
    load      = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      S_IDLE:
        if (hold_full) begin
          state_d = S_START;
          load    = 1'b1;
        end
      S_START:
        if (tick) state_d = S_DATA;
      S_DATA:
        if (tick) begin
          shift_d = shift >> 1;
          if (bit_idx == LAST_BIT)
            state_d = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
        end
      S_PARITY:
        if (tick) state_d = S_STOP;
      S_STOP:
        if (tick && stop_idx == LAST_STOP) begin
          frame_end = 1'b1;
          if (hold_full) begin
            state_d = S_START;
            load    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      default: state_d = S_IDLE;
    endcase
    if (load) shift_d = hold;
    // Line level is derived from the next state so the pin flop lines up
    // with the state register.
    unique case (state_d)
      S_START:  serial_d = 1'b0;
      S_DATA:   serial_d = shift_d[0];
      S_PARITY: serial_d = par;
      default:  serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= S_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shift     <= '0;
      par       <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      serial    <= 1'b1;
      done      <= 1'b0;
    end else begin
      state  <= state_d;
      shift  <= shift_d;
      serial <= serial_d;
      done   <= frame_end;
      if (load) begin
        hold_full <= 1'b0;
        par       <= (^hold) ^ ODD;
      end else if (i_TX_DV && !hold_full) begin
        hold_full <= 1'b1;
        hold      <= i_TX_Byte;
      end
      if (load)
        bit_idx <= '0;
      else if (state == S_DATA && tick)
        bit_idx <= (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
      if (state == S_STOP && tick)
        stop_idx <= (stop_idx == LAST_STOP) ? 1'b0 : 1'b1;
    end
  end

  assign o_TX_Ready  = !hold_full;
  assign o_TX_Active = (state != S_IDLE);
  assign o_TX_Serial = serial;
  assign o_TX_Done   = done;

endmodule
